// File: rtl/rf_scoreboard.sv
// rf_scoreboard: tracks register-file destinations of long-latency ops
// (mul/div/load-miss) from issue to writeback and stalls decode on RAW hazards,
// WAW-depth overflow on the destination, or a full tracker.
//
// Ports
//   clk, arst_n          clock (rising edge), async active-low reset
//   rs1, rs2             decode source indices
//   rs1_used, rs2_used   decode instruction actually reads that source
//   issue_valid/issue_rd tracked long-latency op wants to issue, its destination
//   wb_valid/wb_rd       tracked op writes back this cycle, its destination
//   stall                combinational decode/fetch hold
//   busy                 per-register pending flag (from registered counts)
//   inflight             total outstanding tracked writes (registered)
//   err                  sticky: writeback to a register with nothing pending
module rf_scoreboard #(
  parameter  int NUM_REGS     = 32,
  parameter  int MAX_PER_REG  = 3,
  parameter  int MAX_INFLIGHT = 4,
  localparam int IW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_PER_REG + 1),
  localparam int TW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [IW-1:0]       rs1,
  input  logic [IW-1:0]       rs2,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                issue_valid,
  input  logic [IW-1:0]       issue_rd,
  input  logic                wb_valid,
  input  logic [IW-1:0]       wb_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy,
  output logic [TW-1:0]       inflight,
  output logic                err
);

  // Per-register outstanding-write counts; entry 0 is hardwired to zero so
  // x0 can never look pending.
  logic [NUM_REGS-1:0][CW-1:0] cnt;
  logic accept, ret, rd_full, tot_full, raw;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // Hazard terms all use registered state: a writeback releases its
  // dependents one cycle later, matching when the RF write lands.
  assign raw      = (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]);
  assign rd_full  = issue_valid & (issue_rd != '0) & (cnt[issue_rd] == CW'(MAX_PER_REG));
  assign tot_full = issue_valid & (inflight == TW'(MAX_INFLIGHT));
  assign stall    = raw | rd_full | tot_full;

  assign accept = issue_valid & ~stall & (issue_rd != '0);
  // busy[0] is 0, so this also ignores wb_rd == 0.
  assign ret    = wb_valid & busy[wb_rd];

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic [CW-1:0] q;
    logic          inc, dec;

    assign inc = accept & (issue_rd == IW'(r));
    assign dec = ret & (wb_rd == IW'(r));

    // Issue and retire of the same rd in one cycle cancel out.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)            q <= '0;
      else if (inc && !dec)   q <= q + 1'b1;
      else if (dec && !inc)   q <= q - 1'b1;
    end

    assign cnt[r]  = q;
    assign busy[r] = (q != '0);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && !ret)      inflight <= inflight + 1'b1;
      else if (ret && !accept) inflight <= inflight - 1'b1;
      // Writeback with nothing pending on a real register is a protocol error.
      if (wb_valid && (wb_rd != '0) && !busy[wb_rd]) err <= 1'b1;
    end
  end

endmodule
